// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one frame-memory port between VGA scanout, a frame-clear engine and a pixel writer.
// Latency: mem_a/mem_we/mem_d and wr_ack/wr_err are combinational (0 cycles); vga_data is registered (1 cycle).
// Backpressure: scanout is never stalled; the clear engine pauses on visible cycles; wr_req is held until wr_ack.
//
// Optional feature: define FB_CLEAR_EN to build the clear engine. Without it clear_start is ignored,
// clear_busy/clear_done are tied low and the priority is scanout > writer.
//
// Ports:
//   clka, rstn                     clock, asynchronous active-low reset
//   vga_rd_en, row_addr, col_addr  scanout request (640x480 coordinates, 4x4 pixel replication)
//   vga_data                       registered pixel colour, black during blanking
//   wr_req, wr_x, wr_y, wr_color   writer request (160x120 coordinates)
//   wr_ack, wr_err                 writer grant pulse; wr_err flags an out-of-range (dropped) write
//   clear_start, clear_busy, clear_done   clear engine control and status
//   mem_a, mem_we, mem_d, mem_spo  single-port frame memory with asynchronous read
module fb_arbiter #(
   parameter logic [11:0] BG_COLOR  = 12'h000,
   parameter int          MEM_WORDS = 19200
) (
   input  logic        clka,
   input  logic        rstn,
   input  logic        vga_rd_en,
   input  logic [8:0]  row_addr,
   input  logic [9:0]  col_addr,
   output logic [11:0] vga_data,
   input  logic        wr_req,
   input  logic [7:0]  wr_x,
   input  logic [6:0]  wr_y,
   input  logic [11:0] wr_color,
   output logic        wr_ack,
   output logic        wr_err,
   input  logic        clear_start,
   output logic        clear_busy,
   output logic        clear_done,
   output logic [14:0] mem_a,
   output logic        mem_we,
   output logic [11:0] mem_d,
   input  logic [11:0] mem_spo
);

   localparam logic [14:0] ROW_PITCH = 15'd160;

   logic [14:0] scan_addr;
   logic [14:0] wr_addr;
   logic        wr_in_range;

   // Scanout replicates each stored pixel over a 4x4 block, so the two LSBs of
   // row and column are dropped before forming the linear address.
   assign scan_addr   = 15'(row_addr[8:2]) * ROW_PITCH + 15'(col_addr[9:2]);
   assign wr_addr     = 15'(wr_y) * ROW_PITCH + 15'(wr_x);
   assign wr_in_range = (wr_x < 8'd160) && (wr_y < 7'd120);

   wire unused_addr_lsb = ^{row_addr[1:0], col_addr[1:0]};

   // Clear engine: clr_we marks a cycle in which it actually writes clr_cnt.
   logic        clr_we;
   logic [14:0] clr_cnt;

`ifdef FB_CLEAR_EN
   typedef enum logic [1:0] {
      CLR_IDLE = 2'd0,
      CLR_RUN  = 2'd1,
      CLR_DONE = 2'd2
   } clr_state_t;

   localparam logic [14:0] LAST_ADDR = 15'(MEM_WORDS - 1);

   clr_state_t  clr_state;
   clr_state_t  clr_state_nxt;
   logic [14:0] clr_cnt_nxt;

   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         clr_state <= CLR_IDLE;
         clr_cnt   <= '0;
      end else begin
         clr_state <= clr_state_nxt;
         clr_cnt   <= clr_cnt_nxt;
      end
   end

   always_comb begin
      clr_state_nxt = clr_state;
      clr_cnt_nxt   = clr_cnt;
      clr_we        = 1'b0;
      clear_busy    = 1'b0;
      clear_done    = 1'b0;
      case (clr_state)
         CLR_IDLE: begin
            // clear_start outside IDLE is ignored, so a running clear never restarts.
            if (clear_start) begin
               clr_state_nxt = CLR_RUN;
               clr_cnt_nxt   = '0;
            end
         end
         CLR_RUN: begin
            clear_busy = 1'b1;
            // Visible cycles belong to scanout: hold the counter, no write.
            if (!vga_rd_en) begin
               clr_we = 1'b1;
               if (clr_cnt == LAST_ADDR) begin
                  clr_state_nxt = CLR_DONE;
               end else begin
                  clr_cnt_nxt = clr_cnt + 15'd1;
               end
            end
         end
         CLR_DONE: begin
            // Still busy here so the writer stays blocked for the done cycle.
            clear_busy    = 1'b1;
            clear_done    = 1'b1;
            clr_state_nxt = CLR_IDLE;
         end
         default: begin
            clr_state_nxt = CLR_IDLE;
         end
      endcase
   end
`else
   localparam int unused_mem_words = MEM_WORDS;
   wire unused_clear_start = clear_start;

   assign clr_we     = 1'b0;
   assign clr_cnt    = '0;
   assign clear_busy = 1'b0;
   assign clear_done = 1'b0;
`endif

   // Port ownership: scanout > clear engine > writer > idle.
   always_comb begin
      mem_a  = '0;
      mem_we = 1'b0;
      mem_d  = '0;
      wr_ack = 1'b0;
      wr_err = 1'b0;
      if (vga_rd_en) begin
         mem_a = scan_addr;
      end else if (clear_busy) begin
         if (clr_we) begin
            mem_a  = clr_cnt;
            mem_we = 1'b1;
            mem_d  = BG_COLOR;
         end
      end else if (wr_req) begin
         wr_ack = 1'b1;
         if (wr_in_range) begin
            mem_a  = wr_addr;
            mem_we = 1'b1;
            mem_d  = wr_color;
         end else begin
            wr_err = 1'b1;
         end
      end
   end

   // Blanking cycles output black rather than whatever the memory returns.
   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         vga_data <= '0;
      end else begin
         vga_data <= vga_rd_en ? mem_spo : 12'h000;
      end
   end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Sequencer and arbiter for the single-port 160x120x12 frame memory (19200 words) behind the VGA colour path. Scanout reads, a frame-clear engine and a sprite/game-logic write port all share one memory address bus. Scanout owns the port whenever pixels are visible. Clears and writes are serviced only in blanking cycles, so the displayed image never glitches.

## Interface
- BG_COLOR, 12'h000, fill value used by the clear engine
- MEM_WORDS, 19200, frame memory depth (160*120)
- clka  in  1  system clock; all logic rises on this edge
- rstn  in  1  asynchronous active-low reset
- vga_rd_en  in  1  high during visible pixels; scanout owns the memory this cycle
- row_addr  in  9  VGA row, 0..479
- col_addr  in  10  VGA column, 0..639
- vga_data  out  12  registered pixel colour
- wr_req  in  1  writer request; must hold wr_x, wr_y, wr_color stable until wr_ack
- wr_x  in  8  writer column, 0..159
- wr_y  in  7  writer row, 0..119
- wr_color  in  12  writer colour
- wr_ack  out  1  one-cycle pulse: request consumed
- wr_err  out  1  one-cycle pulse with wr_ack when the coordinate is out of range (write dropped)
- clear_start  in  1  one-cycle pulse: fill memory with BG_COLOR
- clear_busy  out  1  clear engine active
- clear_done  out  1  one-cycle pulse after the final clear write
- mem_a  out  15  memory address (combinational)
- mem_we  out  1  memory write enable (combinational)
- mem_d  out  12  memory write data (combinational)
- mem_spo  in  12  memory asynchronous read data

## Operation
- Each cycle, exactly one owner drives mem_a, in fixed priority: scanout (vga_rd_en=1) > clear engine (clear_busy=1) > writer (wr_req=1) > idle.
- When idle: mem_a=0, mem_we=0, mem_d=0.
- Scanout address: (row_addr>>2)*160 + (col_addr>>2), computed in 15 bits with no truncation. mem_we=0.
- Clear FSM states:
  - IDLE: a clear_start pulse goes to CLEAR and sets cnt=0.
  - CLEAR: in each cycle with vga_rd_en=0, write mem_a=cnt, mem_d=BG_COLOR, then cnt++. When cnt=MEM_WORDS-1 is written, go to DONE.
  - DONE: pulse clear_done for one cycle, then return to IDLE.
- clear_busy=1 in CLEAR and DONE.
- clear_start received while not in IDLE is ignored; the running clear is not restarted.
- Writer is served when it owns the port:
  - If wr_x<160 and wr_y<120: mem_a=wr_y*160+wr_x, mem_we=1, mem_d=wr_color.
  - Otherwise mem_we=0 and wr_err=1.
  - wr_ack is asserted combinationally in the same cycle as the write.
- Writer starvation is permitted while a clear is running. Requests are never dropped; wr_req stays pending.
- Reset, including mid-clear: FSM to IDLE, cnt=0, vga_data=0, wr_ack=0, wr_err=0, clear_busy=0, clear_done=0. Partially cleared memory contents are left as they are.

## Timing
- vga_data latency is 1 cycle: at each rising edge vga_data <= vga_rd_en ? mem_spo : 12'h000. Blanking outputs black.
- Minimum full clear is 19200 non-visible cycles, plus 1 cycle for DONE.
- In the vga_rd_en=1 cycle that preempts a clear, cnt does not advance and no write occurs.
- A writer request issued in an idle cycle is acknowledged in that same cycle (0-cycle latency). The writer drops wr_req or presents new data on the next edge.
- mem_we is never 1 in a cycle where vga_rd_en=1.

## Configuration
- FB_CLEAR_EN defined: clear engine present as described above.
- FB_CLEAR_EN undefined: no clear FSM or counter. clear_start is ignored; clear_busy and clear_done are tied to 0. Priority becomes scanout > writer.

## Test plan
- Reset with rstn=0 mid-clear (cnt=5000), release -> clear_busy=0, vga_data=0; a new clear_start restarts from address 0.
- vga_rd_en=1, row=7, col=13 -> mem_a=1*160+3=163, mem_we=0; with mem_spo=12'hABC, vga_data=12'hABC on the next cycle.
- vga_rd_en=0, wr_req with x=159, y=119, color=12'hF00 -> same cycle: mem_a=19199, mem_we=1, wr_ack=1, wr_err=0.
- wr_req with x=160, y=0 -> wr_ack=1, wr_err=1, mem_we=0.
- clear_start with vga_rd_en held 0 -> 19200 writes of BG_COLOR at addresses 0..19199, clear_done on cycle 19201. A concurrent wr_req gets no ack until after DONE.
- clear_start with vga_rd_en toggling 1/0 each cycle -> no write in any vga_rd_en=1 cycle; total clear time is 38400 cycles ±1; a second clear_start mid-clear is ignored.
